// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the HI/LO registers.
//   Executes mult/multu/div/divu over DATA_WIDTH iterations plus one
//   sign-fixup cycle, and mthi/mtlo in a single cycle.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low clear
//   srca       dividend / multiplicand / mthi-mtlo source
//   srcb       divisor / multiplier
//   mdcontrol  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   start      request, sampled only while idle
//   busy       operation in progress (registered)
//   done       one-cycle pulse when HI/LO are written by mult/div
//   hi, lo     architectural HI/LO registers
// Build option: define MDU_ZERO_SKIP_EN to send trivially-zero multiplies
//   and divide-by-zero straight to the fixup cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo write here
// CALC  | one shift-add / shift-subtract iteration per cycle
// FIX   | apply signs, write HI/LO, pulse done
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  input  logic [2:0]            mdcontrol,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_res;   // signs of operands differ
  logic           neg_rem;   // dividend negative
  logic           div_zero;
  logic [W-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*W-1:0] acc;       // mult: {partial, multiplier}; div: {remainder, quotient}

  logic           a_neg, b_neg, skip;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [2*W-1:0] acc_step, prod_fix;
  logic [W-1:0]   q_fix, r_fix;

  always_comb begin
    a_neg = ~mdcontrol[0] & srca[W-1];
    b_neg = ~mdcontrol[0] & srcb[W-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
  end

`ifdef MDU_ZERO_SKIP_EN
  assign skip = mdcontrol[1] ? (srcb == '0) : ((srca == '0) || (srcb == '0));
`else
  assign skip = 1'b0;
`endif

  // One iteration. The divide shift needs W+1 bits since the shifted
  // remainder can exceed the divisor width before the compare.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    div_sh   = acc[2*W-1:W-1];
    div_diff = div_sh - {1'b0, opnd};
    if (is_div) begin
      if (div_sh >= {1'b0, opnd}) acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else                        acc_step = {div_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    q_fix    = neg_res ? -acc[W-1:0] : acc[W-1:0];
    r_fix    = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!mdcontrol[2]) begin
              is_div   <= mdcontrol[1];
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= mdcontrol[1] & (srcb == '0);
              opnd     <= mdcontrol[1] ? b_mag : a_mag;
              cnt      <= '0;
              busy     <= 1'b1;
              if (skip) begin
                // Preload what a full divide-by-zero run would leave behind
                state <= FIX;
                acc   <= mdcontrol[1] ? {a_mag, {W{1'b1}}} : '0;
              end else begin
                state <= CALC;
                acc   <= mdcontrol[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
              end
            end else if (!mdcontrol[1]) begin
              if (mdcontrol[0]) lo <= srca;
              else              hi <= srca;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= div_zero ? {W{1'b1}} : q_fix;
          end else begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table for mult/div results and latency,
// plus hand sequences for mthi/mtlo, start-while-busy, done/start overlap
// and mid-operation reset.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam int LAT_FULL = W + 1;
`ifdef MDU_ZERO_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] srca, srcb;
  logic [2:0]   mdcontrol;
  logic         start;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .srca(srca), .srcb(srcb),
    .mdcontrol(mdcontrol), .start(start), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   ctl;
    logic [W-1:0] a, b;
    logic [W-1:0] exp_hi, exp_lo;
    bit           zero;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue at the next edge; returns after the edge that raised done (or timeout).
  task automatic run_op(input string name, input logic [2:0] ctl,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
    int  lat;
    bit  busy_gap;
    @(negedge clk);
    start = 1'b1; mdcontrol = ctl; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " busy_after_start"}, 64'(busy), 64'd1);
    lat = 0;
    busy_gap = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_gap = 1'b1;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy_held"}, 64'(busy_gap), 64'd0);
    check({name, " busy_clear_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_m3x7",   3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"divu_100_7",  3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{"div_m7_2",    3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{"div_ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"divu_5_0",    3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{"mult_minsq",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{"div_m7_0",    3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{"mult_zero",   3'b000, 32'd0,        32'h00012345, 32'd0,        32'd0,        1'b1};
    vecs[9]  = '{"div_7_m2",    3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[10] = '{"multu_2p16",  3'b001, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    vecs[11] = '{"mult_5_m1",   3'b000, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};

    reset = 1'b0; start = 1'b0; mdcontrol = 3'b111; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;

    // mthi / mtlo visible right after their edge, no busy/done
    @(negedge clk); start = 1'b1; mdcontrol = 3'b100; srca = 32'h12345678;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h12345678);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    mdcontrol = 3'b101; srca = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo hi_kept", 64'(hi), 64'h12345678);
    check("mtlo busy", 64'(busy), 64'd0);
    mdcontrol = 3'b110; srca = 32'h55555555;
    @(posedge clk); #1;
    mdcontrol = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    check("noop hi", 64'(hi), 64'h12345678);
    check("noop lo", 64'(lo), 64'h9ABCDEF0);
    check("noop busy", 64'(busy), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].ctl, vecs[i].a, vecs[i].b,
             (vecs[i].zero && SKIP_ON) ? 1 : LAT_FULL);
      check({vecs[i].name, " hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, " lo"}, 64'(lo), 64'(vecs[i].exp_lo));
    end

    // done and a new start in the same cycle: the start is taken
    run_op("overlap_divu", 3'b011, 32'd100, 32'd7, LAT_FULL);
    start = 1'b1; mdcontrol = 3'b101; srca = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0;
    check("overlap mtlo lo", 64'(lo), 64'hCAFEF00D);
    check("overlap hi_kept", 64'(hi), 64'd2);
    check("overlap done_cleared", 64'(done), 64'd0);

    // starts and mthi during CALC are ignored; hi holds until FIX
    @(negedge clk); start = 1'b1; mdcontrol = 3'b100; srca = 32'h0BADC0DE;
    @(negedge clk); start = 1'b1; mdcontrol = 3'b001; srca = 32'd3; srcb = 32'd4;
    @(negedge clk);
    check("busy_ign started", 64'(busy), 64'd1);
    mdcontrol = 3'b001; srca = 32'd5; srcb = 32'd5;
    @(negedge clk);
    mdcontrol = 3'b100; srca = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; srca = 32'h77777777; srcb = 32'h66666666;
    check("busy_ign hi_hold", 64'(hi), 64'h0BADC0DE);
    check("busy_ign lo_hold", 64'(lo), 64'hCAFEF00D);
    begin
      int t;
      t = 0;
      while (!done && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check("busy_ign finished", 64'(done), 64'd1);
    end
    check("busy_ign hi", 64'(hi), 64'd0);
    check("busy_ign lo", 64'(lo), 64'd12);

    // reset mid-operation: aborts, clears, no done pulse
    @(negedge clk); start = 1'b1; mdcontrol = 3'b001; srca = 32'd3; srcb = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid hi", 64'(hi), 64'd0);
    check("rst_mid lo", 64'(lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1'b1;
      end
      check("rst_mid no_done", 64'(seen), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
